load_unit: RTL and testbench

- Load-side counterpart of the store byte-enable path in the core's data-memory interface.
- Accepts one RV32I load (LB/LH/LW/LBU/LHU) at a time and issues a single word-aligned read to data memory.
- Waits a variable number of cycles for the read response, then extracts and sign- or zero-extends the addressed byte or halfword.
- Presents the result to register writeback with a valid/ready handshake, and flags misaligned or illegal loads and memory timeouts.

---
 rtl/load_unit_if.sv | 39 +++
 rtl/load_unit.sv | 164 ++++++++++++++++
 tb/tb_load_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/load_unit_if.sv
// Load unit bus bundle: request, data-memory read port and writeback.
// master = requester/memory/writeback side, slave = load unit.
interface load_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [4:0]  req_rd;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        misalign;
  logic        timeout;

  modport master (
    output req_valid, req_funct3, req_addr, req_rd,
    input  req_ready,
    input  mem_re, mem_addr,
    output mem_rvalid, mem_rdata,
    input  wb_valid, wb_data, wb_rd,
    output wb_ready,
    input  misalign, timeout
  );

  modport slave (
    input  req_valid, req_funct3, req_addr, req_rd,
    output req_ready,
    output mem_re, mem_addr,
    input  mem_rvalid, mem_rdata,
    output wb_valid, wb_data, wb_rd,
    input  wb_ready,
    output misalign, timeout
  );
endinterface

// File: rtl/load_unit.sv
// RV32I load unit: one word read per load, byte/half extraction,
// writeback handshake, misalign and memory-timeout reporting.
module load_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic        clk,
  input logic        rst,
  load_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  wbrd_q, wbrd_d;
  logic        mis_q, mis_d;
  logic        to_q, to_d;

  logic        accept;
  logic        bad;
  logic [2:0]  f3_in;
  logic [1:0]  a_lo;

  function automatic logic [31:0] extract(
    input logic [2:0]  f3,
    input logic [1:0]  off,
    input logic [31:0] w
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    unique case (off)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    unique case (f3)
      3'b000: r = {{24{b[7]}}, b};
      3'b100: r = {24'h0, b};
      3'b001: r = {{16{h[15]}}, h};
      3'b101: r = {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign bus.mem_re    = (state_q == REQ);
  assign bus.mem_addr  = addr_q;
  assign bus.wb_valid  = (state_q == RESP);
  assign bus.wb_data   = data_q;
  assign bus.wb_rd     = wbrd_q;
  assign bus.misalign  = mis_q;
  assign bus.timeout   = to_q;

  assign accept = bus.req_valid && bus.req_ready;
  assign f3_in  = bus.req_funct3;
  assign a_lo   = bus.req_addr[1:0];

  // Classify the incoming request as illegal or misaligned
  always_comb begin
    bad = 1'b0;
    unique case (1'b1)
      (f3_in == 3'b011),
      (f3_in == 3'b110),
      (f3_in == 3'b111): bad = 1'b1;
      (f3_in == 3'b001),
      (f3_in == 3'b101): bad = a_lo[0];
      (f3_in == 3'b010): bad = (a_lo != 2'b00);
      default:           bad = 1'b0;
    endcase
  end

  // Next-state and datapath for the load sequence
  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    wbrd_d  = wbrd_q;
    mis_d   = 1'b0;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          f3_d  = f3_in;
          off_d = a_lo;
          rd_d  = bus.req_rd;
          if (bad) begin
            mis_d = 1'b1;
          end else begin
            addr_d  = {bus.req_addr[31:2], 2'b00};
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (bus.mem_rvalid) begin
          data_d  = extract(f3_q, off_q, bus.mem_rdata);
          wbrd_d  = rd_q;
          state_d = RESP;
        end else begin
          cnt_d   = 8'd0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          data_d  = extract(f3_q, off_q, bus.mem_rdata);
          wbrd_d  = rd_q;
          state_d = RESP;
        end else if (cnt_q == LAST) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        if (bus.wb_ready) state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      rd_q    <= 5'd0;
      addr_q  <= 32'd0;
      cnt_q   <= 8'd0;
      data_q  <= 32'd0;
      wbrd_q  <= 5'd0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      wbrd_q  <= wbrd_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit with TIMEOUT = 4.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_load_unit;

  logic clk;
  logic rst;
  int   n_run;
  int   n_fail;

  load_unit_if bus ();

  load_unit #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [2:0] f3, input logic [31:0] a,
                     input logic [4:0] rd);
    bus.req_valid  = 1'b1;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_rd     = rd;
    step();
    bus.req_valid  = 1'b0;
  endtask

  // Load answered in the REQ cycle, consumed immediately
  task automatic fast_load(input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [4:0] rd,
                           input logic [31:0] w, input logic [31:0] exp);
    req(f3, a, rd);
    chk({tag, " mem_re"}, 32'(bus.mem_re), 32'd1);
    chk({tag, " mem_addr"}, bus.mem_addr, {a[31:2], 2'b00});
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = w;
    step();
    bus.mem_rvalid = 1'b0;
    chk({tag, " wb_valid"}, 32'(bus.wb_valid), 32'd1);
    chk({tag, " wb_data"}, bus.wb_data, exp);
    chk({tag, " wb_rd"}, 32'(bus.wb_rd), 32'(rd));
    bus.wb_ready = 1'b1;
    step();
    bus.wb_ready = 1'b0;
    chk({tag, " idle"}, 32'(bus.wb_valid), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] exp;
  } vec_t;

  vec_t sweep [12];

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst             = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_funct3  = 3'd0;
    bus.req_addr    = 32'd0;
    bus.req_rd      = 5'd0;
    bus.mem_rvalid  = 1'b0;
    bus.mem_rdata   = 32'd0;
    bus.wb_ready    = 1'b0;

    sweep[0]  = '{3'b000, 2'd0, 32'h0000_000D};
    sweep[1]  = '{3'b000, 2'd1, 32'hFFFF_FF9C};
    sweep[2]  = '{3'b000, 2'd2, 32'h0000_007B};
    sweep[3]  = '{3'b000, 2'd3, 32'hFFFF_FF8A};
    sweep[4]  = '{3'b100, 2'd0, 32'h0000_000D};
    sweep[5]  = '{3'b100, 2'd1, 32'h0000_009C};
    sweep[6]  = '{3'b100, 2'd2, 32'h0000_007B};
    sweep[7]  = '{3'b100, 2'd3, 32'h0000_008A};
    sweep[8]  = '{3'b001, 2'd0, 32'hFFFF_9C0D};
    sweep[9]  = '{3'b001, 2'd2, 32'hFFFF_8A7B};
    sweep[10] = '{3'b101, 2'd0, 32'h0000_9C0D};
    sweep[11] = '{3'b101, 2'd2, 32'h0000_8A7B};

    // reset state
    step();
    chk("rst req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst mem_re", 32'(bus.mem_re), 32'd0);
    chk("rst wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst misalign", 32'(bus.misalign), 32'd0);
    chk("rst timeout", 32'(bus.timeout), 32'd0);
    chk("rst mem_addr", bus.mem_addr, 32'd0);
    chk("rst wb_data", bus.wb_data, 32'd0);
    chk("rst wb_rd", 32'(bus.wb_rd), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle req_ready", 32'(bus.req_ready), 32'd1);

    // LB at 0x103, data in REQ cycle
    fast_load("lb103", 3'b000, 32'h103, 5'd5, 32'h80FF_1234,
              32'hFFFF_FF80);

    // LHU at 0x102, three WAIT cycles, writeback stalled
    req(3'b101, 32'h102, 5'd7);
    chk("lhu mem_addr", bus.mem_addr, 32'h100);
    chk("lhu mem_re", 32'(bus.mem_re), 32'd1);
    step();
    chk("lhu wait mem_re", 32'(bus.mem_re), 32'd0);
    step();
    step();
    chk("lhu wait ready", 32'(bus.req_ready), 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBEEF_0001;
    step();
    bus.mem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("lhu hold valid", 32'(bus.wb_valid), 32'd1);
      chk("lhu hold data", bus.wb_data, 32'h0000_BEEF);
      chk("lhu hold rd", 32'(bus.wb_rd), 32'd7);
      chk("lhu hold ready", 32'(bus.req_ready), 32'd0);
      chk("lhu hold addr", bus.mem_addr, 32'h100);
      bus.mem_rvalid = (i == 1);
      bus.mem_rdata  = 32'h1111_1111;
      step();
      bus.mem_rvalid = 1'b0;
    end
    chk("lhu stray rvalid", bus.wb_data, 32'h0000_BEEF);
    bus.wb_ready = 1'b1;
    step();
    bus.wb_ready = 1'b0;
    chk("lhu drop valid", 32'(bus.wb_valid), 32'd0);
    chk("lhu addr held", bus.mem_addr, 32'h100);

    // misaligned / illegal requests
    req(3'b010, 32'h0001_0006, 5'd3);
    chk("lw mis pulse", 32'(bus.misalign), 32'd1);
    chk("lw mis mem_re", 32'(bus.mem_re), 32'd0);
    chk("lw mis ready", 32'(bus.req_ready), 32'd1);
    step();
    chk("lw mis clear", 32'(bus.misalign), 32'd0);
    chk("lw mis no wb", 32'(bus.wb_valid), 32'd0);
    req(3'b001, 32'h0001_0005, 5'd3);
    chk("lh mis pulse", 32'(bus.misalign), 32'd1);
    chk("lh mis mem_re", 32'(bus.mem_re), 32'd0);
    step();
    chk("lh mis clear", 32'(bus.misalign), 32'd0);
    chk("lh mis no re", 32'(bus.mem_re), 32'd0);
    req(3'b011, 32'h0001_0000, 5'd3);
    chk("f3 011 pulse", 32'(bus.misalign), 32'd1);
    step();
    chk("f3 011 no re", 32'(bus.mem_re), 32'd0);
    chk("mis addr kept", bus.mem_addr, 32'h100);

    // timeout after four silent WAIT cycles
    req(3'b010, 32'h300, 5'd9);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("to wait", 32'(bus.timeout), 32'd0);
      chk("to wait ready", 32'(bus.req_ready), 32'd0);
    end
    step();
    chk("to pulse", 32'(bus.timeout), 32'd1);
    chk("to ready", 32'(bus.req_ready), 32'd1);
    chk("to no wb", 32'(bus.wb_valid), 32'd0);
    step();
    chk("to clear", 32'(bus.timeout), 32'd0);

    // data in the final WAIT cycle beats the timeout
    req(3'b010, 32'h304, 5'd10);
    step();
    step();
    step();
    step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE_F00D;
    step();
    bus.mem_rvalid = 1'b0;
    chk("race no to", 32'(bus.timeout), 32'd0);
    chk("race wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("race wb_data", bus.wb_data, 32'hCAFE_F00D);
    chk("race wb_rd", 32'(bus.wb_rd), 32'd10);
    bus.wb_ready = 1'b1;
    step();
    bus.wb_ready = 1'b0;
    chk("race done", 32'(bus.timeout), 32'd0);

    // reset during WAIT
    req(3'b010, 32'h400, 5'd11);
    step();
    rst = 1'b1;
    #1;
    chk("mid rst mem_re", 32'(bus.mem_re), 32'd0);
    chk("mid rst ready", 32'(bus.req_ready), 32'd0);
    chk("mid rst addr", bus.mem_addr, 32'd0);
    step();
    rst = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    step();
    bus.mem_rvalid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("post rst wb", 32'(bus.wb_valid), 32'd0);
      chk("post rst to", 32'(bus.timeout), 32'd0);
      chk("post rst mis", 32'(bus.misalign), 32'd0);
      chk("post rst re", 32'(bus.mem_re), 32'd0);
      chk("post rst data", bus.wb_data, 32'd0);
      step();
    end
    chk("post rst ready", 32'(bus.req_ready), 32'd1);
    fast_load("lw200", 3'b010, 32'h200, 5'd12, 32'h1234_5678,
              32'h1234_5678);

    // extraction sweep
    for (int i = 0; i < 12; i++) begin
      fast_load($sformatf("sweep%0d", i), sweep[i].f3,
                {30'h0000_0140, sweep[i].off}, 5'(i + 1),
                32'h8A7B_9C0D, sweep[i].exp);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
